// File: rtl/commit_agg_mask_unit_if.sv
// Issue/commit/grant bus between the vector issue logic, the TPU lanes and the Scalar Unit.
interface commit_agg_mask_unit_if #(
  parameter int NUM_LANES   = 4,
  parameter int WIDTH_ISSUE = 8,
  parameter int BUFF_SIZE   = 8
);
  localparam int NUM_W = $clog2(BUFF_SIZE) + 1;

  logic                             I_Req;
  logic [WIDTH_ISSUE-1:0]           I_Issue_No;
  logic [NUM_LANES-1:0]             I_Lane_Mask;
  logic [NUM_LANES-1:0]             I_Commit_Req;
  logic [NUM_LANES*WIDTH_ISSUE-1:0] I_Commit_No;
  logic                             O_Commit_Req;
  logic [WIDTH_ISSUE-1:0]           O_Commit_No;
  logic                             I_Commit_Grant;
  logic                             O_Full;
  logic                             O_Empty;
  logic [NUM_W-1:0]                 O_Num;
  logic [NUM_LANES-1:0]             O_Err_Unmatched;
  logic                             O_Err_Overflow;

  modport master (
    output I_Req, I_Issue_No, I_Lane_Mask, I_Commit_Req, I_Commit_No, I_Commit_Grant,
    input  O_Commit_Req, O_Commit_No, O_Full, O_Empty, O_Num, O_Err_Unmatched, O_Err_Overflow
  );

  modport slave (
    input  I_Req, I_Issue_No, I_Lane_Mask, I_Commit_Req, I_Commit_No, I_Commit_Grant,
    output O_Commit_Req, O_Commit_No, O_Full, O_Empty, O_Num, O_Err_Unmatched, O_Err_Overflow
  );
endinterface

// File: rtl/commit_agg_mask_unit.sv
// In-order commit aggregator with per-issue lane masks; presents completed issues to the Scalar Unit.
// Optional head-of-queue watchdog (O_Timeout) is enabled by defining COMMIT_AGG_TIMEOUT_EN.
module commit_agg_mask_unit #(
  parameter int NUM_LANES   = 4,
  parameter int BUFF_SIZE   = 8,
  parameter int WIDTH_ISSUE = 8
`ifdef COMMIT_AGG_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                   clock,
  input  logic                   reset,
  commit_agg_mask_unit_if.slave  bus
`ifdef COMMIT_AGG_TIMEOUT_EN
  , output logic                 O_Timeout
`endif
);
  localparam int PW = $clog2(BUFF_SIZE);
  localparam int CW = PW + 1;
  typedef logic [PW-1:0] ptr_t;

  logic [BUFF_SIZE-1:0]   v_q, v_d;
  logic [NUM_LANES-1:0]   mask_q  [BUFF_SIZE];
  logic [NUM_LANES-1:0]   mask_d  [BUFF_SIZE];
  logic [NUM_LANES-1:0]   done_q  [BUFF_SIZE];
  logic [NUM_LANES-1:0]   done_d  [BUFF_SIZE];
  logic [WIDTH_ISSUE-1:0] issue_q [BUFF_SIZE];
  logic [WIDTH_ISSUE-1:0] issue_d [BUFF_SIZE];
  ptr_t                   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   full_q, full_d, empty_q, empty_d;
  logic [NUM_LANES-1:0]   errUnmatched_q, errUnmatched_d;
  logic                   errOverflow_q, errOverflow_d;
  logic                   issueAcc, headDone, retire;

  assign issueAcc = bus.I_Req & ~full_q;
  assign headDone = v_q[rdPtr_q] & (&(done_q[rdPtr_q] | ~mask_q[rdPtr_q]));
  assign retire   = headDone & bus.I_Commit_Grant;

  // Each lane scans outward from the head so the oldest matching entry wins; the
  // entry being written this cycle is checked last, making it the youngest candidate.
  always_comb begin
    ptr_t                   idx;
    logic                   hit;
    logic [WIDTH_ISSUE-1:0] laneNo;
    v_d            = v_q;
    mask_d         = mask_q;
    done_d         = done_q;
    issue_d        = issue_q;
    wrPtr_d        = wrPtr_q;
    rdPtr_d        = rdPtr_q;
    errUnmatched_d = '0;
    idx            = '0;
    hit            = 1'b0;
    laneNo         = '0;
    if (retire) begin
      v_d[rdPtr_q]    = 1'b0;
      mask_d[rdPtr_q] = '0;
      done_d[rdPtr_q] = '0;
      rdPtr_d         = rdPtr_q + 1'b1;
    end
    if (issueAcc) begin
      v_d[wrPtr_q]     = 1'b1;
      mask_d[wrPtr_q]  = bus.I_Lane_Mask;
      done_d[wrPtr_q]  = '0;
      issue_d[wrPtr_q] = bus.I_Issue_No;
      wrPtr_d          = wrPtr_q + 1'b1;
    end
    for (int j = 0; j < NUM_LANES; j++) begin
      laneNo = bus.I_Commit_No[j*WIDTH_ISSUE +: WIDTH_ISSUE];
      hit    = 1'b0;
      if (bus.I_Commit_Req[j]) begin
        for (int k = 0; k < BUFF_SIZE; k++) begin
          idx = rdPtr_q + ptr_t'(k);
          if (!hit && v_q[idx] && mask_q[idx][j] && !done_q[idx][j] && issue_q[idx] == laneNo) begin
            done_d[idx][j] = 1'b1;
            hit            = 1'b1;
          end
        end
        if (!hit && issueAcc && bus.I_Lane_Mask[j] && bus.I_Issue_No == laneNo) begin
          done_d[wrPtr_q][j] = 1'b1;
          hit                = 1'b1;
        end
        errUnmatched_d[j] = ~hit;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (issueAcc && !retire) begin
      count_d = count_q + 1'b1;
    end else if (!issueAcc && retire) begin
      count_d = count_q - 1'b1;
    end
    full_d        = (count_d == CW'(BUFF_SIZE));
    empty_d       = (count_d == '0);
    errOverflow_d = bus.I_Req & full_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v_q            <= '0;
      wrPtr_q        <= '0;
      rdPtr_q        <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      errUnmatched_q <= '0;
      errOverflow_q  <= 1'b0;
      for (int k = 0; k < BUFF_SIZE; k++) begin
        mask_q[k]  <= '0;
        done_q[k]  <= '0;
        issue_q[k] <= '0;
      end
    end else begin
      v_q            <= v_d;
      mask_q         <= mask_d;
      done_q         <= done_d;
      issue_q        <= issue_d;
      wrPtr_q        <= wrPtr_d;
      rdPtr_q        <= rdPtr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      errUnmatched_q <= errUnmatched_d;
      errOverflow_q  <= errOverflow_d;
    end
  end

  assign bus.O_Commit_Req    = headDone;
  assign bus.O_Commit_No     = headDone ? issue_q[rdPtr_q] : '0;
  assign bus.O_Full          = full_q;
  assign bus.O_Empty         = empty_q;
  assign bus.O_Num           = count_q;
  assign bus.O_Err_Unmatched = errUnmatched_q;
  assign bus.O_Err_Overflow  = errOverflow_q;

`ifdef COMMIT_AGG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_q, tmo_d;

  // Counts only while a valid head waits on lanes; saturates so the flag stays up until retire.
  always_comb begin
    tmo_d = tmo_q;
    if (retire || !v_q[rdPtr_q]) begin
      tmo_d = '0;
    end else if (!headDone && tmo_q != TW'(TIMEOUT_CYCLES)) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign O_Timeout = (tmo_q == TW'(TIMEOUT_CYCLES));
`endif
endmodule

// File: tb/tb_commit_agg_mask_unit.sv
// Directed bench for commit_agg_mask_unit: expected commit numbers are queued at issue and
// popped at each grant; status flags and error pulses are checked at fixed points.
module tb_commit_agg_mask_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] expQ[$];
`ifdef COMMIT_AGG_TIMEOUT_EN
  logic O_Timeout;
`endif

  commit_agg_mask_unit_if #(.NUM_LANES(4), .WIDTH_ISSUE(8), .BUFF_SIZE(8)) bus ();

  commit_agg_mask_unit #(
    .NUM_LANES(4), .BUFF_SIZE(8), .WIDTH_ISSUE(8)
`ifdef COMMIT_AGG_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef COMMIT_AGG_TIMEOUT_EN
    , .O_Timeout(O_Timeout)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic [7:0] no, input logic [3:0] mask);
    bus.I_Req          = req;
    bus.I_Issue_No     = no;
    bus.I_Lane_Mask    = mask;
    bus.I_Commit_Req   = '0;
    bus.I_Commit_No    = '0;
    bus.I_Commit_Grant = 1'b0;
  endtask

  task automatic setCommit(input int lane, input logic [7:0] no);
    bus.I_Commit_Req[lane]      = 1'b1;
    bus.I_Commit_No[lane*8 +: 8] = no;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for a presented commit, checks it against the scoreboard, then grants it.
  task automatic popGrant(input string tag);
    logic [7:0] exp;
    int waited;
    waited = 0;
    while (!bus.O_Commit_Req && waited < 40) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_req"}, {31'd0, bus.O_Commit_Req}, 32'd1);
    exp = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
    checkOutput({tag, "_no"}, {24'd0, bus.O_Commit_No}, {24'd0, exp});
    bus.I_Commit_Grant = 1'b1;
    tick();
    bus.I_Commit_Grant = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    applyStimulus(1'b0, 8'd0, 4'd0);
    reset = 1'b1;
    tick();
    tick();
    checkOutput("rst_req",   {31'd0, bus.O_Commit_Req}, 32'd0);
    checkOutput("rst_no",    {24'd0, bus.O_Commit_No}, 32'd0);
    checkOutput("rst_full",  {31'd0, bus.O_Full}, 32'd0);
    checkOutput("rst_empty", {31'd0, bus.O_Empty}, 32'd1);
    checkOutput("rst_num",   {28'd0, bus.O_Num}, 32'd0);
    checkOutput("rst_unm",   {28'd0, bus.O_Err_Unmatched}, 32'd0);
    checkOutput("rst_ovf",   {31'd0, bus.O_Err_Overflow}, 32'd0);
    reset = 1'b0;
    tick();

    // Four lanes finishing #5 at staggered times.
    applyStimulus(1'b1, 8'd5, 4'b1111); expQ.push_back(8'd5); tick();
    applyStimulus(1'b0, 8'd0, 4'd0);
    checkOutput("t1_num", {28'd0, bus.O_Num}, 32'd1);
    checkOutput("t1_empty", {31'd0, bus.O_Empty}, 32'd0);
    setCommit(0, 8'd5); tick();
    applyStimulus(1'b0, 8'd0, 4'd0);
    setCommit(1, 8'd5); setCommit(2, 8'd5); tick();
    applyStimulus(1'b0, 8'd0, 4'd0);
    checkOutput("t1_unm", {28'd0, bus.O_Err_Unmatched}, 32'd0);
    tick();
    checkOutput("t1_req_early", {31'd0, bus.O_Commit_Req}, 32'd0);
    setCommit(3, 8'd5); tick();
    applyStimulus(1'b0, 8'd0, 4'd0);
    checkOutput("t1_req_lat", {31'd0, bus.O_Commit_Req}, 32'd1);
    popGrant("t1");
    checkOutput("t1_empty_after", {31'd0, bus.O_Empty}, 32'd1);
    checkOutput("t1_req_after", {31'd0, bus.O_Commit_Req}, 32'd0);

    // Younger entry completes first but must wait behind the older one.
    applyStimulus(1'b1, 8'd1, 4'b0011); expQ.push_back(8'd1); tick();
    applyStimulus(1'b1, 8'd2, 4'b0001); expQ.push_back(8'd2); tick();
    applyStimulus(1'b0, 8'd0, 4'd0);
    setCommit(0, 8'd2); tick();
    applyStimulus(1'b0, 8'd0, 4'd0);
    checkOutput("t2_hold", {31'd0, bus.O_Commit_Req}, 32'd0);
    setCommit(0, 8'd1); setCommit(1, 8'd1); tick();
    applyStimulus(1'b0, 8'd0, 4'd0);
    checkOutput("t2_req1", {31'd0, bus.O_Commit_Req}, 32'd1);
    popGrant("t2a");
    checkOutput("t2_req2", {31'd0, bus.O_Commit_Req}, 32'd1);
    popGrant("t2b");

    // Commit in the issue cycle lands through the bypass.
    applyStimulus(1'b1, 8'd7, 4'b0100); setCommit(2, 8'd7); expQ.push_back(8'd7); tick();
    applyStimulus(1'b0, 8'd0, 4'd0);
    checkOutput("t3_req", {31'd0, bus.O_Commit_Req}, 32'd1);
    checkOutput("t3_unm", {28'd0, bus.O_Err_Unmatched}, 32'd0);
    popGrant("t3");

    // Fill, overflow with simultaneous retire, then an unmatched lane-3 commit.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(10 + i), 4'b0000); expQ.push_back(8'(10 + i)); tick();
    end
    applyStimulus(1'b0, 8'd0, 4'd0);
    checkOutput("t4_full", {31'd0, bus.O_Full}, 32'd1);
    checkOutput("t4_num8", {28'd0, bus.O_Num}, 32'd8);
    checkOutput("t4_head", {24'd0, bus.O_Commit_No}, {24'd0, expQ[0]});
    void'(expQ.pop_front());
    applyStimulus(1'b1, 8'd50, 4'b0000); bus.I_Commit_Grant = 1'b1; tick();
    applyStimulus(1'b0, 8'd0, 4'd0);
    checkOutput("t4_ovf", {31'd0, bus.O_Err_Overflow}, 32'd1);
    checkOutput("t4_num7", {28'd0, bus.O_Num}, 32'd7);
    checkOutput("t4_notfull", {31'd0, bus.O_Full}, 32'd0);
    setCommit(3, 8'd99); tick();
    applyStimulus(1'b0, 8'd0, 4'd0);
    checkOutput("t4_ovf_clr", {31'd0, bus.O_Err_Overflow}, 32'd0);
    checkOutput("t4_unm", {28'd0, bus.O_Err_Unmatched}, 32'h8);
    tick();
    checkOutput("t4_unm_clr", {28'd0, bus.O_Err_Unmatched}, 32'd0);
    for (int i = 0; i < 7; i++) popGrant("t4_drain");
    checkOutput("t4_empty", {31'd0, bus.O_Empty}, 32'd1);

    // Duplicate issue numbers: one commit marks only the older entry.
    applyStimulus(1'b1, 8'd3, 4'b0001); expQ.push_back(8'd3); tick();
    applyStimulus(1'b1, 8'd3, 4'b0001); expQ.push_back(8'd3); tick();
    applyStimulus(1'b0, 8'd0, 4'd0);
    setCommit(0, 8'd3); tick();
    applyStimulus(1'b0, 8'd0, 4'd0);
    popGrant("t5a");
    checkOutput("t5_second_wait", {31'd0, bus.O_Commit_Req}, 32'd0);
    checkOutput("t5_num", {28'd0, bus.O_Num}, 32'd1);
    setCommit(0, 8'd3); tick();
    applyStimulus(1'b0, 8'd0, 4'd0);
    checkOutput("t5_req2", {31'd0, bus.O_Commit_Req}, 32'd1);
    popGrant("t5b");

    // Grant with nothing presented is ignored.
    bus.I_Commit_Grant = 1'b1; tick();
    bus.I_Commit_Grant = 1'b0;
    checkOutput("t6_num", {28'd0, bus.O_Num}, 32'd0);

    // Reset while an entry is complete discards it.
    applyStimulus(1'b1, 8'd9, 4'b0000); tick();
    applyStimulus(1'b0, 8'd0, 4'd0);
    checkOutput("t7_pre", {31'd0, bus.O_Commit_Req}, 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    checkOutput("t7_req", {31'd0, bus.O_Commit_Req}, 32'd0);
    checkOutput("t7_empty", {31'd0, bus.O_Empty}, 32'd1);
    tick();
    checkOutput("t7_req_later", {31'd0, bus.O_Commit_Req}, 32'd0);

`ifdef COMMIT_AGG_TIMEOUT_EN
    applyStimulus(1'b1, 8'd20, 4'b0001); expQ.push_back(8'd20); tick();
    applyStimulus(1'b0, 8'd0, 4'd0);
    for (int i = 0; i < 15; i++) tick();
    checkOutput("t8_tmo_before", {31'd0, O_Timeout}, 32'd0);
    tick();
    checkOutput("t8_tmo", {31'd0, O_Timeout}, 32'd1);
    setCommit(0, 8'd20); tick();
    applyStimulus(1'b0, 8'd0, 4'd0);
    checkOutput("t8_tmo_hold", {31'd0, O_Timeout}, 32'd1);
    popGrant("t8");
    checkOutput("t8_tmo_clr", {31'd0, O_Timeout}, 32'd0);
`endif

    checkOutput("sb_empty", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
